// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 8 x 8-bit register file.
package reg_file_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;

  typedef logic signed [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0]        reg_addr_t;
  typedef reg_data_t [NUM_REGS-1:0] reg_array_t;
  typedef logic [NUM_REGS-1:0]      reg_valid_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: data and valid muxes over the storage array.
// With REG_FILE_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  reg_array_t        i_regs,
  input  reg_valid_t        i_valid,
  input  logic [ADDR_W-1:0] i_addr,
`ifdef REG_FILE_BYPASS_EN
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
`endif
  output logic [DATA_W-1:0] o_data_c,
  output logic              o_valid_c
);

  reg_addr_t w_addr;

  assign w_addr = reg_addr_t'(i_addr);

`ifdef REG_FILE_BYPASS_EN
  logic w_hit;

  assign w_hit = i_wr_en && (i_wr_addr == i_addr);

  // Forwarded write data wins over the stored value on an address match
  always_comb begin
    o_data_c  = DATA_W'(i_regs[w_addr]);
    o_valid_c = i_valid[w_addr];
    if (w_hit) begin
      o_data_c  = i_wr_data;
      o_valid_c = 1'b1;
    end
  end
`else
  always_comb begin
    o_data_c  = DATA_W'(i_regs[w_addr]);
    o_valid_c = i_valid[w_addr];
  end
`endif

endmodule

// File: rtl/reg_file.sv
// 8 x 8-bit register file: one synchronous write port, two combinational read ports,
// per-register written-since-reset valid bits. Optional macro: REG_FILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              OUT1_VALID,
  output logic              OUT2_VALID
);

  reg_array_t r_regs;
  reg_valid_t r_valid;
  logic       w_wr_en;
  reg_addr_t  w_wr_addr;

  assign w_wr_en   = WRITE && !BUSYWAIT && !RESET;
  assign w_wr_addr = reg_addr_t'(INADDRESS);

  // Storage and valid bits; reset beats any write or stall
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_regs  <= '0;
      r_valid <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wr_addr]  <= reg_data_t'(IN);
      r_valid[w_wr_addr] <= 1'b1;
    end
  end

  reg_file_read_port u_rd1 (
    .i_regs    (r_regs),
    .i_valid   (r_valid),
    .i_addr    (OUT1ADDRESS),
`ifdef REG_FILE_BYPASS_EN
    .i_wr_en   (w_wr_en),
    .i_wr_addr (INADDRESS),
    .i_wr_data (IN),
`endif
    .o_data_c  (OUT1),
    .o_valid_c (OUT1_VALID)
  );

  reg_file_read_port u_rd2 (
    .i_regs    (r_regs),
    .i_valid   (r_valid),
    .i_addr    (OUT2ADDRESS),
`ifdef REG_FILE_BYPASS_EN
    .i_wr_en   (w_wr_en),
    .i_wr_addr (INADDRESS),
    .i_wr_data (IN),
`endif
    .o_data_c  (OUT2),
    .o_valid_c (OUT2_VALID)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic against an array model.
module tb_reg_file;

  logic       CLK = 1'b0;
  logic       RESET, WRITE, BUSYWAIT;
  logic [7:0] IN;
  logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
  logic [7:0] OUT1, OUT2;
  logic       OUT1_VALID, OUT2_VALID;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_regs  [8];
  logic       m_valid [8];

  always #5 CLK = ~CLK;

  reg_file dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN          (IN),
    .INADDRESS   (INADDRESS),
    .WRITE       (WRITE),
    .BUSYWAIT    (BUSYWAIT),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT2ADDRESS (OUT2ADDRESS),
    .OUT1        (OUT1),
    .OUT2        (OUT2),
    .OUT1_VALID  (OUT1_VALID),
    .OUT2_VALID  (OUT2_VALID)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected read result for the current inputs and model state
  task automatic exp_rd(input logic [2:0] a, output logic [7:0] d, output logic v);
    d = m_regs[a];
    v = m_valid[a];
`ifdef REG_FILE_BYPASS_EN
    if (!RESET && WRITE && !BUSYWAIT && INADDRESS == a) begin
      d = IN;
      v = 1'b1;
    end
`endif
  endtask

  // Drive one cycle, check both ports mid-cycle, then advance the model across the edge
  task automatic cycle(input logic rst, input logic wr, input logic bw, input logic [7:0] din,
                       input logic [2:0] wa, input logic [2:0] a1, input logic [2:0] a2,
                       input string tag);
    logic [7:0] e1, e2;
    logic       v1, v2;
    RESET = rst; WRITE = wr; BUSYWAIT = bw; IN = din;
    INADDRESS = wa; OUT1ADDRESS = a1; OUT2ADDRESS = a2;
    @(negedge CLK);
    exp_rd(a1, e1, v1);
    exp_rd(a2, e2, v2);
    chk({tag, "_out1"}, 32'(OUT1), 32'(e1));
    chk({tag, "_out2"}, 32'(OUT2), 32'(e2));
    chk({tag, "_v1"},   32'(OUT1_VALID), 32'(v1));
    chk({tag, "_v2"},   32'(OUT2_VALID), 32'(v2));
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i]  = 8'h00;
        m_valid[i] = 1'b0;
      end
    end else if (wr && !bw) begin
      m_regs[wa]  = din;
      m_valid[wa] = 1'b1;
    end
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 8; a++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'(a), 3'(7 - a), tag);
  endtask

  initial begin
    RESET = 1'b1; WRITE = 1'b1; BUSYWAIT = 1'b0; IN = 8'h5A;
    INADDRESS = 3'd0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    for (int i = 0; i < 8; i++) begin
      m_regs[i]  = 8'h00;
      m_valid[i] = 1'b0;
    end
    @(posedge CLK);
    #1;
    read_all("reset");

    // Basic write/read, operands feeding an add
    cycle(1'b0, 1'b1, 1'b0, 8'd45, 3'd1, 3'd0, 3'd0, "wr_r1");
    cycle(1'b0, 1'b1, 1'b0, 8'd30, 3'd2, 3'd1, 3'd2, "wr_r2");
    cycle(1'b0, 1'b0, 1'b0, 8'd0,  3'd0, 3'd1, 3'd2, "rd_r1r2");
    chk("r1_const", 32'(OUT1), 32'd45);
    chk("r2_const", 32'(OUT2), 32'd30);
    chk("alu_add",  32'(8'(OUT1 + OUT2)), 32'd75);

    // Stall for three edges, commit on the fourth
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 8'h3A, 3'd5, 3'd5, 3'd5, "stall");
    chk("stall_r5_invalid", 32'(OUT1_VALID), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h3A, 3'd5, 3'd5, 3'd1, "stall_rel");
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd5, 3'd5, "stall_post");
    chk("r5_const", 32'(OUT1), 32'h3A);
    chk("r5_valid", 32'(OUT1_VALID), 32'd1);

    // Reset beats a simultaneous write
    cycle(1'b1, 1'b1, 1'b0, 8'hF9, 3'd3, 3'd3, 3'd5, "rst_prio");
    read_all("rst_clear");

    // Read-during-write to the same address
    cycle(1'b0, 1'b1, 1'b0, 8'h26, 3'd4, 3'd4, 3'd4, "rdw_pre");
    cycle(1'b0, 1'b1, 1'b0, 8'h3A, 3'd4, 3'd4, 3'd4, "rdw");
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd4, 3'd4, "rdw_post");
    chk("rdw_after", 32'(OUT2), 32'h3A);

    // Full sweep of all read pairs
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h11 * i), 3'(i), 3'(i), 3'(7 - i), "sweep_wr");
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'(a), 3'(b), "sweep_rd");
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, "neg_chk");
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    @(negedge CLK);
    OUT1ADDRESS = 3'd7;
    #1;
    chk("neg_r7", 32'(OUT1), 32'h77);
    @(posedge CLK);
    #1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'b0 + ($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
